ram_arbiter: RTL and testbench

- Shares the single byte-addressed data RAM between two requesters: requester 0 (CPU load/store) and requester 1 (DMA/debug loader).
- Round-robin arbitration, request/ack handshake, and a 3-state sequencer that drives the RAM's write strobe, ctrl, address and write-data inputs.
- Checks each access for alignment and range before touching memory.
- Sits between the core/DMA and the RAM; the RAM itself is unchanged (combinational read, write on posedge).

---
 rtl/ram_arb_pkg.sv | 36 +++
 rtl/ram_access_check.sv | 40 ++++
 rtl/ram_arbiter.sv | 147 ++++++++++++++
 tb/tb_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types, ctrl encodings and helpers for the RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // Illegal encodings report a size of one byte; they are rejected elsewhere.
    function automatic logic [2:0] size_from_ctrl(input logic [2:0] ctrl);
        case (ctrl)
            LS_H, LS_HU: size_from_ctrl = 3'd2;
            LS_W:        size_from_ctrl = 3'd4;
            default:     size_from_ctrl = 3'd1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_access_check.sv
// ============================================================================
// Module   : ram_access_check
// Brief    : Combinational legality check (encoding, alignment, range).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_access_check
    import ram_arb_pkg::*;
#(
    parameter int RAM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic [2:0]        ctrl,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    output logic              error
);

    localparam int AW1 = ADDR_W + 1;

    logic [AW1-1:0] w_last;
    logic           w_bad_ctrl;
    logic           w_bad_store;
    logic           w_misalign;
    logic           w_range;

    // One extra bit keeps the end-address sum from wrapping.
    assign w_last      = {1'b0, addr} + AW1'(size_from_ctrl(ctrl)) - AW1'(1);
    assign w_range     = (w_last >= AW1'(RAM_BYTES));
    assign w_bad_ctrl  = (ctrl == 3'b011) || (ctrl[2:1] == 2'b11);
    assign w_bad_store = we && ((ctrl == LS_BU) || (ctrl == LS_HU));
    assign w_misalign  = (((ctrl == LS_H) || (ctrl == LS_HU)) && addr[0])
                      || ((ctrl == LS_W) && (addr[1:0] != 2'b00));

    assign error = w_bad_ctrl || w_bad_store || w_misalign || w_range;

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Brief    : Round-robin CPU/DMA arbiter and sequencer for the data RAM.
//            Define RAM_ARB_LOCK_EN to add per-requester lock for atomic RMW.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RAM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [2:0]        ctrl0,
    input  logic [2:0]        ctrl1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wData0,
    input  logic [31:0]       wData1,
`ifdef RAM_ARB_LOCK_EN
    input  logic [1:0]        lock,
`endif
    output logic [1:0]        ack,
    output logic [31:0]       rData,
    output logic              err,
    output logic              ramWrite,
    output logic [2:0]        ramCtrl,
    output logic [ADDR_W-1:0] ramAddress,
    output logic [31:0]       ramWData,
    input  logic [31:0]       ramRData
);

    state_t            r_state;
    logic              r_last_grant;
    logic              r_winner;
    logic              r_we;
    logic [2:0]        r_ctrl;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [1:0]        r_ack;

    logic [1:0]        w_elig;
    logic              w_pick;
    logic              w_err;

`ifdef RAM_ARB_LOCK_EN
    logic              r_locked;
    logic              r_lock_id;
    logic              w_locked;

    assign w_locked = r_locked && (r_lock_id ? lock[1] : lock[0]);
`endif

    always_comb begin
        w_elig = req;
`ifdef RAM_ARB_LOCK_EN
        if (w_locked) begin
            w_elig = r_lock_id ? (req & 2'b10) : (req & 2'b01);
        end
`endif
        case (w_elig)
            2'b10:   w_pick = REQ_DMA;
            2'b11:   w_pick = ~r_last_grant;
            default: w_pick = REQ_CPU;
        endcase
    end

    ram_access_check #(
        .RAM_BYTES (RAM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_check (
        .ctrl  (r_ctrl),
        .we    (r_we),
        .addr  (r_addr),
        .error (w_err)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_DMA;
            r_winner     <= REQ_CPU;
            r_we         <= 1'b0;
            r_ctrl       <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_rdata      <= 32'h0;
            r_err        <= 1'b0;
            r_ack        <= 2'b00;
`ifdef RAM_ARB_LOCK_EN
            r_locked     <= 1'b0;
            r_lock_id    <= REQ_CPU;
`endif
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                IDLE: begin
`ifdef RAM_ARB_LOCK_EN
                    r_locked <= w_locked;
`endif
                    if (|w_elig) begin
                        r_winner <= w_pick;
                        r_we     <= w_pick ? we[1]  : we[0];
                        r_ctrl   <= w_pick ? ctrl1  : ctrl0;
                        r_addr   <= w_pick ? addr1  : addr0;
                        r_wdata  <= w_pick ? wData1 : wData0;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_rdata <= (r_we || w_err) ? 32'h0 : ramRData;
                    r_err   <= w_err;
                    r_ack   <= r_winner ? 2'b10 : 2'b01;
                    r_state <= RESP;
                end
                RESP: begin
                    r_last_grant <= r_winner;
`ifdef RAM_ARB_LOCK_EN
                    r_locked     <= r_winner ? lock[1] : lock[0];
                    r_lock_id    <= r_winner;
`endif
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobe is decoded from registers so an async reset removes it at once.
    assign ramWrite   = (r_state == ACCESS) && r_we && !w_err;
    assign ramCtrl    = r_ctrl;
    assign ramAddress = r_addr;
    assign ramWData   = r_wdata;
    assign ack        = r_ack;
    assign rData      = r_rdata;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed self-checking bench for ram_arbiter with a byte RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [1:0]  req, we;
    logic [2:0]  ctrl0, ctrl1;
    logic [31:0] addr0, addr1, wData0, wData1;
`ifdef RAM_ARB_LOCK_EN
    logic [1:0]  lock;
`endif
    logic [1:0]  ack;
    logic [31:0] rData;
    logic        err;
    logic        ramWrite;
    logic [2:0]  ramCtrl;
    logic [31:0] ramAddress, ramWData, ramRData;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    ram_arbiter #(.RAM_BYTES(1024), .ADDR_W(32)) dut (
        .Clock(Clock), .Reset(Reset), .req(req), .we(we),
        .ctrl0(ctrl0), .ctrl1(ctrl1), .addr0(addr0), .addr1(addr1),
        .wData0(wData0), .wData1(wData1),
`ifdef RAM_ARB_LOCK_EN
        .lock(lock),
`endif
        .ack(ack), .rData(rData), .err(err), .ramWrite(ramWrite),
        .ramCtrl(ramCtrl), .ramAddress(ramAddress), .ramWData(ramWData),
        .ramRData(ramRData)
    );

    // Byte RAM model: combinational sized read, write on posedge.
    logic [7:0] mem [0:1023];
    logic       mem_clear;
    logic [9:0] ma;
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        ma = ramAddress[9:0];
        b0 = mem[ma];
        b1 = mem[ma + 10'd1];
        b2 = mem[ma + 10'd2];
        b3 = mem[ma + 10'd3];
        case (ramCtrl)
            3'b000:  ramRData = {{24{b0[7]}}, b0};
            3'b100:  ramRData = {24'h0, b0};
            3'b001:  ramRData = {{16{b1[7]}}, b1, b0};
            3'b101:  ramRData = {16'h0, b1, b0};
            3'b010:  ramRData = {b3, b2, b1, b0};
            default: ramRData = 32'h0;
        endcase
    end

    always @(posedge Clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h0;
        end else if (ramWrite) begin
            mem[ma] <= ramWData[7:0];
            if (ramCtrl[1:0] != 2'b00) mem[ma + 10'd1] <= ramWData[15:8];
            if (ramCtrl[1:0] == 2'b10) begin
                mem[ma + 10'd2] <= ramWData[23:16];
                mem[ma + 10'd3] <= ramWData[31:24];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One request on one requester; reports ack latency and strobe count.
    task automatic txn(input logic id, input logic w, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat,
                       output int wcnt, output logic [1:0] ackv);
        @(negedge Clock);
        if (id) begin we[1] = w; ctrl1 = c; addr1 = a; wData1 = d; end
        else    begin we[0] = w; ctrl0 = c; addr0 = a; wData0 = d; end
        req[id] = 1'b1;
        lat = 0; wcnt = 0; ackv = 2'b00; rd = 32'h0; e = 1'b0;
        while (lat < 20 && ackv == 2'b00) begin
            @(negedge Clock);
            lat++;
            if (ramWrite) wcnt++;
            if (ack != 2'b00) begin ackv = ack; rd = rData; e = err; end
        end
        req[id] = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [19];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, wcnt, n, cyc;
        logic [1:0]  ackv;
        logic [1:0]  order [6];
        int          when  [6];

        vecs[0]  = '{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 3'b001, 32'h011, 32'h0,        32'h0,        1'b1};
        vecs[3]  = '{1'b1, 3'b010, 32'h102, 32'h11111111, 32'h0,        1'b1};
        vecs[4]  = '{1'b1, 3'b100, 32'h000, 32'h000000FF, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 3'b010, 32'd1022, 32'h0,       32'h0,        1'b1};
        vecs[6]  = '{1'b1, 3'b000, 32'h005, 32'h00000080, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 3'b000, 32'h005, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[8]  = '{1'b0, 3'b100, 32'h005, 32'h0,        32'h00000080, 1'b0};
        vecs[9]  = '{1'b0, 3'b001, 32'h010, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[10] = '{1'b0, 3'b101, 32'h010, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[11] = '{1'b1, 3'b001, 32'h032, 32'hAAAA1234, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 3'b010, 32'h030, 32'h0,        32'h12340000, 1'b0};
        vecs[13] = '{1'b0, 3'b011, 32'h000, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b1, 3'b101, 32'h000, 32'h00001111, 32'h0,        1'b1};
        vecs[15] = '{1'b0, 3'b010, 32'h3FC, 32'h0,        32'h0,        1'b0};
        vecs[16] = '{1'b0, 3'b000, 32'h400, 32'h0,        32'h0,        1'b1};
        vecs[17] = '{1'b0, 3'b000, 32'h3FF, 32'h0,        32'h0,        1'b0};
        vecs[18] = '{1'b0, 3'b111, 32'h000, 32'h0,        32'h0,        1'b1};

        Reset = 1'b1; mem_clear = 1'b1;
        req = 2'b00; we = 2'b00; ctrl0 = 3'b000; ctrl1 = 3'b000;
        addr0 = 32'h0; addr1 = 32'h0; wData0 = 32'h0; wData1 = 32'h0;
`ifdef RAM_ARB_LOCK_EN
        lock = 2'b00;
`endif
        repeat (2) @(negedge Clock);
        mem_clear = 1'b0;
        check("rst_ack",      32'(ack),        32'h0);
        check("rst_rdata",    rData,           32'h0);
        check("rst_err",      32'(err),        32'h0);
        check("rst_ramwrite", 32'(ramWrite),   32'h0);
        check("rst_ramaddr",  ramAddress,      32'h0);
        check("rst_ramctrl",  32'(ramCtrl),    32'h0);
        Reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            txn(1'b0, vecs[i].w, vecs[i].c, vecs[i].a, vecs[i].d, rd, e, lat, wcnt, ackv);
            check($sformatf("v%0d_ack", i),   32'(ackv), 32'h1);
            check($sformatf("v%0d_lat", i),   32'(lat),  32'd2);
            check($sformatf("v%0d_rdata", i), rd,        vecs[i].exp_rd);
            check($sformatf("v%0d_err", i),   32'(e),    32'(vecs[i].exp_err));
            check($sformatf("v%0d_wr", i),    32'(wcnt),
                  (vecs[i].w && !vecs[i].exp_err) ? 32'd1 : 32'd0);
        end

        // DMA path; also leaves lastGrant on DMA so the tie goes to CPU.
        txn(1'b1, 1'b0, 3'b010, 32'h010, 32'h0, rd, e, lat, wcnt, ackv);
        check("dma_ack",   32'(ackv), 32'h2);
        check("dma_lat",   32'(lat),  32'd2);
        check("dma_rdata", rd,        32'hDEADBEEF);

        // Both requesting continuously: strict alternation, one ack per 3 cycles.
        @(negedge Clock);
        we = 2'b00; ctrl0 = 3'b010; addr0 = 32'h010; ctrl1 = 3'b010; addr1 = 32'h030;
        req = 2'b11;
        n = 0; cyc = 0;
        while (n < 6 && cyc < 60) begin
            @(negedge Clock);
            cyc++;
            if (ack != 2'b00) begin
                check("rr_onehot", 32'(ack == 2'b01 || ack == 2'b10), 32'h1);
                check("rr_rdata", rData, ack[1] ? 32'h12340000 : 32'hDEADBEEF);
                order[n] = ack; when[n] = cyc; n++;
            end
        end
        req = 2'b00;
        check("rr_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr_order%0d", i), 32'(order[i]), (i % 2 == 1) ? 32'h2 : 32'h1);
            check($sformatf("rr_cycle%0d", i), 32'(when[i]), 32'(2 + 3 * i));
        end

        // Reset during ACCESS of a store: nothing written, no ack.
        txn(1'b0, 1'b1, 3'b010, 32'h020, 32'hCAFEF00D, rd, e, lat, wcnt, ackv);
        check("pre_store_wr", 32'(wcnt), 32'd1);
        @(negedge Clock);
        we[0] = 1'b1; ctrl0 = 3'b010; addr0 = 32'h020; wData0 = 32'h12345678; req[0] = 1'b1;
        @(negedge Clock);
        check("mid_ramwrite", 32'(ramWrite), 32'h1);
        Reset = 1'b1;
        #1;
        check("rst_drop_write", 32'(ramWrite), 32'h0);
        check("rst_drop_ack",   32'(ack),      32'h0);
        @(negedge Clock);
        check("rst_hold_ack", 32'(ack), 32'h0);
        req = 2'b00; Reset = 1'b0;
        @(negedge Clock);
        check("rst_after_ack", 32'(ack), 32'h0);
        txn(1'b0, 1'b0, 3'b010, 32'h020, 32'h0, rd, e, lat, wcnt, ackv);
        check("rst_reload_lat",   32'(lat), 32'd2);
        check("rst_reload_rdata", rd,       32'hCAFEF00D);

`ifdef RAM_ARB_LOCK_EN
        // CPU holds lock for three accesses; DMA waits despite requesting.
        @(negedge Clock);
        we = 2'b00; ctrl0 = 3'b010; addr0 = 32'h010; ctrl1 = 3'b010; addr1 = 32'h020;
        req[0] = 1'b1; lock[0] = 1'b1;
        @(negedge Clock);
        req[1] = 1'b1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge Clock);
            cyc++;
            if (ack != 2'b00) begin
                order[n] = ack; n++;
                if (n == 3) begin req[0] = 1'b0; lock[0] = 1'b0; end
                if (ack[1]) req[1] = 1'b0;
            end
        end
        req = 2'b00; lock = 2'b00;
        check("lock_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lock_order%0d", i), 32'(order[i]), (i == 3) ? 32'h2 : 32'h1);
        end
`endif

        repeat (2) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
